// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding,
// stream framing constants and the header word-count clamp.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } load_state_t;

  localparam int WORD_STRIDE    = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_COUNT_W    = 4;

  // Limits the header word count to the memory capacity so the address never wraps.
  function automatic logic [HDR_COUNT_W-1:0] clamp_count(
    input logic [HDR_COUNT_W-1:0] n,
    input logic [HDR_COUNT_W-1:0] max_n
  );
    logic [HDR_COUNT_W-1:0] result;
    if (n > max_n) begin
      result = max_n;
    end else begin
      result = n;
    end
    return result;
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader,
// bundled with the PC-enable status outputs.
interface instruction_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  byteValid;
  logic [7:0]            byteData;
  logic                  byteReady;
  logic                  imemWriteEnable;
  logic [ADDR_WIDTH-1:0] imemWriteAddress;
  logic [DATA_WIDTH-1:0] imemWriteData;
  logic                  enablePC;
  logic                  loadDone;

  modport master (
    output byteValid, byteData,
    input  byteReady, imemWriteEnable, imemWriteAddress, imemWriteData,
    input  enablePC, loadDone
  );

  modport slave (
    input  byteValid, byteData,
    output byteReady, imemWriteEnable, imemWriteAddress, imemWriteData,
    output enablePC, loadDone
  );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Shifts stream bytes (most significant first) into a word and flags the
// shift that completes it.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_shift_en,
  input  logic                  i_clear,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_complete
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]      r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;

  // Shift register and byte counter; clear only resynchronises the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_shift_en) begin
      r_word     <= {r_word[DATA_WIDTH-9:0], i_byte};
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

  assign o_word          = r_word;
  assign o_word_complete = i_shift_en && (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: reads a header count and big-endian words from a byte stream,
// writes them to instruction memory from address 0, then enables the PC.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WORDS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_loader_if.slave  bus
);

  load_state_t           r_state;
  load_state_t           w_next_state;
  logic [HDR_COUNT_W-1:0] r_count;
  logic [HDR_COUNT_W-1:0] r_index;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write_en;
  logic                  r_byte_ready;
  logic                  r_enable_pc;
  logic                  r_load_done;
  logic                  w_handshake;
  logic                  w_shift_en;
  logic                  w_clear;
  logic                  w_word_complete;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_handshake = bus.byteValid && r_byte_ready;
  assign w_shift_en  = w_handshake && (r_state == ST_ASSEMBLE);
  assign w_clear     = (r_state == ST_COUNT);

  instruction_loader_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_assembler (
    .clock           (clock),
    .reset           (reset),
    .i_shift_en      (w_shift_en),
    .i_clear         (w_clear),
    .i_byte          (bus.byteData),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COUNT: begin
        if (w_handshake) begin
          if (bus.byteData[HDR_COUNT_W-1:0] == '0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_ASSEMBLE;
          end
        end else begin
          w_next_state = ST_COUNT;
        end
      end
      ST_ASSEMBLE: begin
        if (w_word_complete) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_ASSEMBLE;
        end
      end
      ST_WRITE: begin
        if ((r_index + HDR_COUNT_W'(1)) == r_count) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ASSEMBLE;
        end
      end
      ST_DONE: w_next_state = ST_DONE;
      default: w_next_state = ST_COUNT;
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_COUNT;
      r_count      <= '0;
      r_index      <= '0;
      r_addr       <= '0;
      r_write_en   <= 1'b0;
      r_byte_ready <= 1'b0;
      r_enable_pc  <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_COUNT && w_handshake) begin
        r_count <= clamp_count(bus.byteData[HDR_COUNT_W-1:0], HDR_COUNT_W'(MAX_WORDS));
      end
      if (r_state == ST_WRITE) begin
        r_index <= r_index + HDR_COUNT_W'(1);
        r_addr  <= r_addr + ADDR_WIDTH'(WORD_STRIDE);
      end
      r_write_en   <= (w_next_state == ST_WRITE);
      r_byte_ready <= (w_next_state == ST_COUNT) || (w_next_state == ST_ASSEMBLE);
      r_enable_pc  <= (w_next_state == ST_DONE);
      r_load_done  <= (w_next_state == ST_DONE);
    end
  end

  assign bus.byteReady        = r_byte_ready;
  assign bus.imemWriteEnable  = r_write_en;
  assign bus.imemWriteAddress = r_addr;
  assign bus.imemWriteData    = w_word;
  assign bus.enablePC         = r_enable_pc;
  assign bus.loadDone         = r_load_done;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as the
// stream is driven and matched against observed write strobes.
module tb_instruction_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instruction_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus();

  instruction_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WORDS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int zero_writes = 0;
  int en_cycle = -1;
  int en_with_we = 0;
  int last_strobe = -1;

  task automatic tick();
    wr_t o;
    @(posedge clock);
    #1;
    cyc++;
    if (bus.imemWriteEnable === 1'b1) begin
      o.addr = bus.imemWriteAddress;
      o.data = bus.imemWriteData;
      obs_q.push_back(o);
      last_strobe = cyc;
      if (bus.imemWriteAddress == 5'd0) zero_writes++;
      if (bus.enablePC === 1'b1) en_with_we++;
    end
    if (bus.enablePC === 1'b1 && en_cycle < 0) en_cycle = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok, output int hs_cyc);
    bit rdy;
    ok = 1'b0;
    hs_cyc = -1;
    bus.byteValid = 1'b1;
    bus.byteData  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = bus.byteReady;
      tick();
      if (rdy) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    bit k;
    int h;
    ok = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], k, h);
      if (!k) ok = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bus.byteValid = 1'b0;
    for (int i = 0; i < budget && bus.loadDone !== 1'b1; i++) tick();
    ok = (bus.loadDone === 1'b1);
  endtask

  task automatic clear_tracking();
    exp_q.delete();
    obs_q.delete();
    zero_writes = 0;
    en_cycle = -1;
    en_with_we = 0;
    last_strobe = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.byteValid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_tracking();
  endtask

  task automatic test_reset();
    bit rdy_seen;
    reset = 1'b1;
    bus.byteValid = 1'b0;
    bus.byteData = 8'h00;
    tick();
    tick();
    total++; if (bus.byteReady !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.byteReady); end
    total++; if (bus.imemWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.imemWriteEnable); end
    total++; if (bus.imemWriteAddress !== 5'd0) begin bad++; $display("FAIL reset_addr: got %h want 00", bus.imemWriteAddress); end
    total++; if (bus.imemWriteData !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.imemWriteData); end
    total++; if (bus.enablePC !== 1'b0) begin bad++; $display("FAIL reset_enpc: got %b want 0", bus.enablePC); end
    total++; if (bus.loadDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.loadDone); end
    reset = 1'b0;
    clear_tracking();
    rdy_seen = 1'b0;
    for (int i = 0; i < 5 && !rdy_seen; i++) begin
      tick();
      rdy_seen = (bus.byteReady === 1'b1);
    end
    total++; if (!rdy_seen) begin bad++; $display("FAIL reset_ready_after: got 0 want 1"); end
  endtask

  task automatic test_two_words();
    bit ok, sent;
    bit k;
    int h;
    wr_t e, o;
    do_reset();
    send_byte(8'h02, k, h);
    e.addr = 5'h00; e.data = 32'h2008_0005; exp_q.push_back(e);
    send_word(32'h2008_0005, sent);
    e.addr = 5'h04; e.data = 32'h2409_0007; exp_q.push_back(e);
    send_word(32'h2409_0007, ok);
    sent = sent && ok && k;
    wait_done(20, ok);
    total++; if (!(sent && ok)) begin bad++; $display("FAIL two_word_progress: sent=%b done=%b want 1 1", sent, ok); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL two_word_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL two_word_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
    total++; if (en_cycle != last_strobe + 1) begin bad++; $display("FAIL two_word_enpc_timing: got cycle %0d want %0d", en_cycle, last_strobe + 1); end
    total++; if (en_with_we != 0) begin bad++; $display("FAIL two_word_enpc_overlap: got %0d want 0", en_with_we); end
    total++; if (bus.byteReady !== 1'b0) begin bad++; $display("FAIL two_word_ready_done: got %b want 0", bus.byteReady); end
  endtask

  task automatic test_zero_header();
    bit k;
    int h;
    int extra;
    do_reset();
    send_byte(8'h00, k, h);
    total++; if (!k || en_cycle != h) begin bad++; $display("FAIL zero_enpc_timing: got cycle %0d want %0d", en_cycle, h); end
    extra = 0;
    bus.byteValid = 1'b1;
    bus.byteData = 8'h55;
    for (int i = 0; i < 6; i++) begin
      if (bus.byteReady === 1'b1) extra++;
      tick();
    end
    bus.byteValid = 1'b0;
    total++; if (extra != 0) begin bad++; $display("FAIL zero_extra_ready: got %0d want 0", extra); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL zero_strobes: got %0d want 0", obs_q.size()); end
    total++; if (bus.loadDone !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", bus.loadDone); end
  endtask

  task automatic test_clamp();
    bit ok, sent, k;
    int h;
    int extra;
    logic [31:0] w;
    wr_t e, o;
    do_reset();
    send_byte(8'h0F, k, h);
    sent = k;
    for (int i = 0; i < 8; i++) begin
      w = 32'hA000_0000 + 32'(i) * 32'h0102_0304;
      e.addr = 5'(i * 4); e.data = w; exp_q.push_back(e);
      send_word(w, ok);
      sent = sent && ok;
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      bus.byteValid = 1'b1;
      bus.byteData = 8'hE0 + 8'(i);
      for (int j = 0; j < 3; j++) begin
        if (bus.byteReady === 1'b1) extra++;
        tick();
      end
    end
    wait_done(20, ok);
    total++; if (!(sent && ok)) begin bad++; $display("FAIL clamp_progress: sent=%b done=%b want 1 1", sent, ok); end
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL clamp_count: got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL clamp_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
    total++; if (extra != 0) begin bad++; $display("FAIL clamp_extra_ready: got %0d want 0", extra); end
    total++; if (zero_writes != 1) begin bad++; $display("FAIL clamp_addr0_writes: got %0d want 1", zero_writes); end
  endtask

  task automatic test_gaps();
    bit ok, sent, k;
    int h;
    int start;
    logic [31:0] w;
    wr_t e, o;
    do_reset();
    start = cyc;
    send_byte(8'h01, k, h);
    sent = k;
    w = 32'hAABB_CCDD;
    e.addr = 5'h00; e.data = w; exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      bus.byteValid = 1'b0;
      tick();
      send_byte(w[i*8 +: 8], k, h);
      sent = sent && k;
    end
    wait_done(20, ok);
    total++; if (!(sent && ok)) begin bad++; $display("FAIL gap_progress: sent=%b done=%b want 1 1", sent, ok); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL gap_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL gap_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
    total++; if (en_cycle - start < 10) begin bad++; $display("FAIL gap_duration: got %0d cycles want >= 10", en_cycle - start); end
  endtask

  task automatic test_reset_mid();
    bit ok, sent, k;
    int h;
    wr_t e, o;
    do_reset();
    send_byte(8'h02, k, h);
    sent = k;
    e.addr = 5'h00; e.data = 32'hCAFE_0001; exp_q.push_back(e);
    send_word(32'hCAFE_0001, ok); sent = sent && ok;
    send_byte(8'h77, k, h); sent = sent && k;
    send_byte(8'h66, k, h); sent = sent && k;
    reset = 1'b1;
    bus.byteValid = 1'b0;
    tick();
    reset = 1'b0;
    total++; if (en_cycle != -1) begin bad++; $display("FAIL mid_enpc_early: got cycle %0d want none", en_cycle); end
    send_byte(8'h01, k, h); sent = sent && k;
    e.addr = 5'h00; e.data = 32'h1122_3344; exp_q.push_back(e);
    send_word(32'h1122_3344, ok); sent = sent && ok;
    wait_done(20, ok);
    total++; if (!(sent && ok)) begin bad++; $display("FAIL mid_progress: sent=%b done=%b want 1 1", sent, ok); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL mid_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mid_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
    total++; if (en_cycle != last_strobe + 1) begin bad++; $display("FAIL mid_enpc_timing: got cycle %0d want %0d", en_cycle, last_strobe + 1); end
  endtask

  task automatic test_reset_collide();
    bit ok, sent, k, rdy;
    int h;
    wr_t e, o;
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 5 && !rdy; i++) begin
      tick();
      rdy = (bus.byteReady === 1'b1);
    end
    total++; if (!rdy) begin bad++; $display("FAIL collide_ready: got 0 want 1"); end
    bus.byteValid = 1'b1;
    bus.byteData = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.byteValid = 1'b0;
    tick();
    tick();
    total++; if (bus.loadDone !== 1'b0) begin bad++; $display("FAIL collide_dropped: got done=%b want 0", bus.loadDone); end
    send_byte(8'h01, k, h);
    sent = k;
    e.addr = 5'h00; e.data = 32'h5A5A_A5A5; exp_q.push_back(e);
    send_word(32'h5A5A_A5A5, ok); sent = sent && ok;
    wait_done(20, ok);
    total++; if (!(sent && ok)) begin bad++; $display("FAIL collide_progress: sent=%b done=%b want 1 1", sent, ok); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL collide_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL collide_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  initial begin
    bus.byteValid = 1'b0;
    bus.byteData = 8'h00;
    test_reset();
    test_two_words();
    test_zero_header();
    test_clamp();
    test_gaps();
    test_reset_mid();
    test_reset_collide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory. After reset it accepts a byte stream (one header byte, then big-endian instruction words), assembles 32-bit words, and writes them into consecutive instruction-memory word addresses starting at 0. It holds the program counter disabled until the load completes, then asserts `enablePC` so the single-cycle core begins fetching from address 0.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width.
- `ADDR_WIDTH`, 5, byte address width. Matches the PC width.
- `MAX_WORDS`, 8, capacity in words: 2^ADDR_WIDTH / 4.

Ports:
- `clock`  in  1  single clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `byteValid`  in  1  `byteData` holds a valid byte.
- `byteData`  in  8  stream byte.
- `byteReady`  out  1  loader can accept a byte this cycle.
- `imemWriteEnable`  out  1  one-cycle write strobe to instruction memory.
- `imemWriteAddress`  out  ADDR_WIDTH  byte address: 0, 4, 8, …
- `imemWriteData`  out  DATA_WIDTH  assembled instruction word.
- `enablePC`  out  1  high once loading is complete. Drives the core's PC enable.
- `loadDone`  out  1  same timing as `enablePC`. Status output for the bench.

## Operation
- A byte transfers on any rising edge where `byteValid && byteReady`. Bytes presented while `byteReady` is low are ignored; they are neither consumed nor queued.
- States:
  - COUNT (entered from reset): the header byte sets the word count N from `byteData[3:0]`.
    - N = 0: go to DONE.
    - N > MAX_WORDS: clamp to MAX_WORDS.
    - Otherwise go to ASSEMBLE.
  - ASSEMBLE: accepts 4 bytes, most significant first, shifting them in as `word = {word[23:0], byte}`. The 4th accepted byte moves the state to WRITE.
  - WRITE: lasts exactly 1 cycle and asserts `imemWriteEnable`.
    - `imemWriteData` holds the assembled word.
    - `imemWriteAddress` holds 4 × (word index).
    - On exit the word index and address are incremented. If the number of words written equals N, go to DONE; otherwise return to ASSEMBLE.
  - DONE: terminal. Only `reset` leaves this state.
- Address arithmetic: address increments by 4 per word, modulo 2^ADDR_WIDTH. The clamp guarantees no wrap occurs within one load.
- Output values by state:
  - `byteReady`: 1 in COUNT and ASSEMBLE; 0 in WRITE and DONE.
  - `imemWriteEnable`: 1 only in WRITE.
  - `enablePC` and `loadDone`: 1 only in DONE.
- Reset values: state COUNT, `byteReady` 0 during the reset cycle, `imemWriteEnable` 0, `imemWriteAddress` 0, `imemWriteData` 0, word index 0, byte counter 0, `enablePC` 0, `loadDone` 0.
- Reset mid-load: abandons any partial word and restarts at COUNT with address 0. Words already written stay in memory; the loader never clears them.
- `reset` takes priority over a simultaneous byte handshake. The byte is dropped.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Latency from the 4th byte handshake (edge k) to the write strobe:
  - `imemWriteEnable` is high during cycle k+1.
  - Memory captures the word at edge k+2.
  - `byteReady` returns at cycle k+2 if more words remain.
- Throughput: 5 cycles per word at best (4 byte cycles + 1 write cycle).
- `enablePC` rises in the cycle after the final WRITE cycle. It never rises in the same cycle as `imemWriteEnable`, so the core cannot fetch a word before it is stored.
- Header with N = 0: `enablePC` rises one cycle after the header handshake.
- Back-to-back `byteValid` with no gaps is supported. Gaps of any length in ASSEMBLE hold state and the partial word.

## Structure
- Shared package holds:
  - state encoding: COUNT, ASSEMBLE, WRITE, DONE (2-bit);
  - `WORD_STRIDE` = 4;
  - `BYTES_PER_WORD` = 4;
  - header count field width = 4.
- One sub-module is natural: `word_assembler`. It contains the 4-byte shift register, 2-bit byte counter and `wordComplete` flag, with shift-enable and clear inputs.
- The top module holds the FSM, address/index counters and output registers.

## Test plan
- Header 0x02, bytes 20 08 00 05 24 09 00 07 back-to-back. Required response:
  - writes 0x2008_0005 @ 0x00 and 0x2409_0007 @ 0x04;
  - `enablePC` rises exactly 1 cycle after the second strobe;
  - exactly 2 strobes in total.
- Header 0x00 → no write strobe; `enablePC` = 1 one cycle after the header handshake; further bytes see `byteReady` = 0.
- Header 0x0F with 8 words, then 4 extra bytes → writes to addresses 0x00–0x1C only. Extra bytes are not accepted, and address 0x00 is not overwritten.
- Header 0x01, `byteValid` toggling 1/0 every cycle over bytes AA BB CC DD → single write of 0xAABB_CCDD @ 0x00; the idle gaps add cycles but not data.
- Header 0x02 plus 6 bytes, then reset for 1 cycle, then header 0x01 with bytes 11 22 33 44. Required response:
  - the first word (@ 0x00) is written once, then reset drops the partial second word;
  - after reset, 0x1122_3344 is written @ 0x00;
  - `enablePC` = 0 throughout until the new load finishes.
- Reset asserted in the same cycle as a byte handshake in COUNT → byte dropped; the next accepted byte is treated as the header.
